alu_muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer for the multi-cycle CPU (MULT, MULTU, DIV, DIVU).
- Owns no adder. It borrows the shared 32-bit ALU through a req/gnt handshake, issuing one ALU_ADD or ALU_SUB per granted cycle.
- Holds the HI/LO result registers that MFHI/MFLO read.
- The main control FSM arbitrates the ALU. It grants only in cycles where it does not need the ALU itself.

---
 rtl/alu_muldiv_seq_pkg.sv | 31 +++
 rtl/alu_muldiv_seq_neg_cond.sv | 12 +
 rtl/alu_muldiv_seq.sv | 219 +++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation and state encodings, ALU opcodes and op-decoding helpers.
package alu_muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  function automatic logic is_div(input op_e code);
    return code[1];
  endfunction

  function automatic logic is_signed_op(input op_e code);
    return code[0];
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_neg_cond.sv
// neg_cond: conditional two's-complement negation of a W-bit value.
module neg_cond #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that borrows the shared ALU via req/gnt.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise divides yield zero.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_c
);

  localparam int CW = $clog2(ITER);

  state_e        r_state, w_state_nx;
  op_e           r_op;
  logic [31:0]   r_rs, r_rt;
  logic [31:0]   r_acc_hi, r_acc_lo, r_mdv;
  logic [31:0]   w_acc_hi_nx, w_acc_lo_nx, w_mdv_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_sgn_q;
  logic [31:0]   r_hi, r_lo, r_alu_a, r_alu_b;
  logic [3:0]    r_alu_op;
  logic          r_busy, r_done, r_alu_req;
  logic [31:0]   w_a_nx, w_b_nx;
  logic [3:0]    w_op_nx;
  logic          w_rs_neg, w_rt_neg, w_use_alu, w_step;
  logic [31:0]   w_rs_abs, w_rt_abs;
  logic          w_mul_carry;
  logic [31:0]   w_mul_hi, w_mul_lo, w_div_hi, w_div_lo;
  logic [63:0]   w_prod;
  logic [31:0]   w_hi_fix, w_lo_fix;

  assign w_rs_neg = is_signed_op(r_op) & r_rs[31];
  assign w_rt_neg = is_signed_op(r_op) & r_rt[31];

  neg_cond #(.W(32)) u_abs_rs (.i_neg(w_rs_neg), .i_val(r_rs), .o_val(w_rs_abs));
  neg_cond #(.W(32)) u_abs_rt (.i_neg(w_rt_neg), .i_val(r_rt), .o_val(w_rt_abs));
  neg_cond #(.W(64)) u_neg_prod (.i_neg(r_sgn_q), .i_val({r_acc_hi, r_acc_lo}), .o_val(w_prod));

  // Multiply step: carry out of the borrowed adder is recovered by an unsigned compare.
  assign w_mul_carry = (alu_c < r_alu_b);
  assign w_mul_hi    = {w_mul_carry, alu_c[31:1]};
  assign w_mul_lo    = {alu_c[0], r_acc_lo[31:1]};

`ifdef MULDIV_DIV_EN
  logic        r_sgn_r;
  logic [32:0] w_div_r33;
  logic        w_div_ge;
  logic [31:0] w_quot, w_rem;

  assign w_use_alu = 1'b1;
  assign w_div_r33 = {r_acc_hi, r_acc_lo[31]};
  assign w_div_ge  = w_div_r33[32] | (w_div_r33[31:0] >= r_mdv);
  assign w_div_hi  = w_div_ge ? alu_c : w_div_r33[31:0];
  assign w_div_lo  = {r_acc_lo[30:0], w_div_ge};

  neg_cond #(.W(32)) u_neg_quot (.i_neg(r_sgn_q), .i_val(r_acc_lo), .o_val(w_quot));
  neg_cond #(.W(32)) u_neg_rem  (.i_neg(r_sgn_r), .i_val(r_acc_hi), .o_val(w_rem));

  assign w_hi_fix = is_div(r_op) ? w_rem  : w_prod[63:32];
  assign w_lo_fix = is_div(r_op) ? w_quot : w_prod[31:0];
`else
  // Divides keep full timing but never touch the ALU and produce zero.
  assign w_use_alu = ~is_div(r_op);
  assign w_div_hi  = r_acc_hi;
  assign w_div_lo  = r_acc_lo;
  assign w_hi_fix  = is_div(r_op) ? 32'd0 : w_prod[63:32];
  assign w_lo_fix  = is_div(r_op) ? 32'd0 : w_prod[31:0];
`endif

  assign w_step = w_use_alu ? alu_gnt : 1'b1;

  // Next-state and accumulator update.
  always_comb begin
    w_state_nx  = r_state;
    w_acc_hi_nx = r_acc_hi;
    w_acc_lo_nx = r_acc_lo;
    w_mdv_nx    = r_mdv;
    w_cnt_nx    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nx = S_PREP;
        else       w_state_nx = S_IDLE;
      end
      S_PREP: begin
        w_cnt_nx    = {CW{1'b0}};
        w_acc_hi_nx = 32'd0;
        if (is_div(r_op)) begin
          w_acc_lo_nx = w_rs_abs;
          w_mdv_nx    = w_rt_abs;
        end else begin
          w_acc_lo_nx = w_rt_abs;
          w_mdv_nx    = w_rs_abs;
        end
        w_state_nx = S_ITER;
      end
      S_ITER: begin
        if (w_step) begin
          if (is_div(r_op)) begin
            w_acc_hi_nx = w_div_hi;
            w_acc_lo_nx = w_div_lo;
          end else begin
            w_acc_hi_nx = w_mul_hi;
            w_acc_lo_nx = w_mul_lo;
          end
          if (r_cnt == CW'(ITER - 1)) begin
            w_state_nx = S_FIX;
          end else begin
            w_cnt_nx = r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_nx = S_ITER;
        end
      end
      S_FIX:   w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // ALU operands are registered from the next accumulator state so they hold while stalled.
  always_comb begin
    w_a_nx  = r_alu_a;
    w_b_nx  = r_alu_b;
    w_op_nx = r_alu_op;
    if (w_state_nx == S_ITER && w_use_alu) begin
      if (is_div(r_op)) begin
        w_a_nx  = {w_acc_hi_nx[30:0], w_acc_lo_nx[31]};
        w_b_nx  = w_mdv_nx;
        w_op_nx = ALU_SUB;
      end else begin
        w_a_nx  = w_acc_hi_nx;
        w_b_nx  = w_acc_lo_nx[0] ? w_mdv_nx : 32'd0;
        w_op_nx = ALU_ADD;
      end
    end else begin
      w_a_nx  = r_alu_a;
      w_b_nx  = r_alu_b;
      w_op_nx = r_alu_op;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MULTU;
      r_rs      <= 32'd0;
      r_rt      <= 32'd0;
      r_acc_hi  <= 32'd0;
      r_acc_lo  <= 32'd0;
      r_mdv     <= 32'd0;
      r_cnt     <= {CW{1'b0}};
      r_sgn_q   <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_alu_a   <= 32'd0;
      r_alu_b   <= 32'd0;
      r_alu_op  <= ALU_ADD;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_alu_req <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_sgn_r   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_acc_hi <= w_acc_hi_nx;
      r_acc_lo <= w_acc_lo_nx;
      r_mdv    <= w_mdv_nx;
      r_cnt    <= w_cnt_nx;
      if (r_state == S_IDLE && start) begin
        r_op <= op_e'(op);
        r_rs <= rs_val;
        r_rt <= rt_val;
      end
      if (r_state == S_PREP) begin
        r_sgn_q <= w_rs_neg ^ w_rt_neg;
`ifdef MULDIV_DIV_EN
        r_sgn_r <= w_rs_neg;
`endif
      end
      if (r_state == S_FIX) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
      r_alu_a   <= w_a_nx;
      r_alu_b   <= w_b_nx;
      r_alu_op  <= w_op_nx;
      r_alu_req <= (w_state_nx == S_ITER) && w_use_alu;
      r_busy    <= (w_state_nx == S_PREP) || (w_state_nx == S_ITER) || (w_state_nx == S_FIX);
      r_done    <= (w_state_nx == S_DONE);
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign alu_req = r_alu_req;
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_op  = r_alu_op;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Table-driven bench for alu_muldiv_seq with an ALU model and a result scoreboard.
// Expected divide results follow the MULDIV_DIV_EN build setting.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, alu_gnt;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, alu_req;
  logic [31:0] hi, lo, alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;

  alu_muldiv_seq #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  // Shared ALU model.
  assign alu_c = (alu_op == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    bit          mode;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          req;
  } exp_t;

  exp_t sb[$];
  vec_t tv[13];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit mode, input logic [31:0] ehi, input logic [31:0] elo,
                        input int glitch, input string nm);
    exp_t        e, got;
    int          cyc, req_cnt, viol, busy_bad;
    logic [31:0] pa, pb;
    logic        preq, pgnt;
    bit          seen, nodiv;
    nodiv = o[1] && !DIV_EN;
    e.hi  = nodiv ? 32'd0 : ehi;
    e.lo  = nodiv ? 32'd0 : elo;
    e.cyc = (mode && !nodiv) ? 67 : 35;
    e.req = nodiv ? 0 : (mode ? 64 : 32);
    @(negedge clk);
    pa = alu_a; pb = alu_b; preq = alu_req; pgnt = 1'b1;
    op = o; rs_val = a; rt_val = b; start = 1'b1; alu_gnt = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; cyc = 1; req_cnt = 0; viol = 0; busy_bad = 0; seen = 1'b0;
    forever begin
      alu_gnt = mode ? ((cyc % 2) == 1) : 1'b1;
      if (cyc == glitch) begin
        start = 1'b1; op = 2'b10; rs_val = 32'd999; rt_val = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (alu_req) req_cnt++;
      if (!preq && !alu_req && (alu_a !== pa || alu_b !== pb)) viol++;
      if (preq && !pgnt && (alu_a !== pa || alu_b !== pb)) viol++;
      preq = alu_req; pgnt = alu_gnt; pa = alu_a; pb = alu_b;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_bad++;
      if (cyc >= 400) break;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; alu_gnt = 1'b1;
    chk({nm, " done_seen"}, {31'd0, seen}, 32'd1);
    if (seen && sb.size() > 0) begin
      got = sb.pop_front();
      chk({nm, " hi"}, hi, got.hi);
      chk({nm, " lo"}, lo, got.lo);
      chk({nm, " latency"}, cyc, got.cyc);
      chk({nm, " req_cycles"}, req_cnt, got.req);
      chk({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({nm, " busy_gaps"}, busy_bad, 32'd0);
      chk({nm, " operand_toggles"}, viol, 32'd0);
    end else begin
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    tv[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    tv[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tv[2]  = '{2'b00, 32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000};
    tv[3]  = '{2'b01, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
    tv[4]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001};
    tv[5]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000001, 32'hFFFFFFFE};
    tv[6]  = '{2'b10, 32'd100,      32'd7,        1'b0, 32'd2,        32'd14};
    tv[7]  = '{2'b11, 32'hFFFFFF9C, 32'd7,        1'b0, 32'hFFFFFFFE, 32'hFFFFFFF2};
    tv[8]  = '{2'b10, 32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 32'hFFFFFFFF};
    tv[9]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000};
    tv[10] = '{2'b11, 32'd100,      32'hFFFFFFF9, 1'b1, 32'd2,        32'hFFFFFFF2};
    tv[11] = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 1'b0, 32'hFFFFFFFB, 32'h00000001};
    tv[12] = '{2'b01, 32'h00003039, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFF, 32'hFFFF9F8E};

    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0; alu_gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset alu_req", {31'd0, alu_req}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset alu_a", alu_a, 32'd0);
    chk("reset alu_b", alu_b, 32'd0);
    chk("reset alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(tv[i].op, tv[i].rs, tv[i].rt, tv[i].mode, tv[i].hi, tv[i].lo, -1,
             $sformatf("vec%0d", i));
    end

    // Reset in the middle of ITER step 10 aborts and clears HI/LO.
    @(negedge clk);
    op = 2'b00; rs_val = 32'h0000FFFF; rt_val = 32'h00000003; start = 1'b1; alu_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("midrun busy", {31'd0, busy}, 32'd1);
    chk("midrun lo held", lo, tv[12].lo);
    rst = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort alu_req", {31'd0, alu_req}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Restart after abort, with a stray start pulse while busy.
    run_op(2'b00, 32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000, 5, "post_reset");
    run_op(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 9, "divu_stall");

    chk("scoreboard empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
